// File: rtl/pcie_msix_pkg.sv
// pcie_msix_pkg
//   Shared constants for the MSI-X request engine: FSM state encoding and
//   the completion status codes reported on m_status_code.
package pcie_msix_pkg;

  // FSM encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_WAIT    = 2'd2;
  localparam logic [1:0] ST_HOLDOFF = 2'd3;

  // Completion status codes
  localparam logic [1:0] MSIX_ST_OK      = 2'd0;
  localparam logic [1:0] MSIX_ST_FAIL    = 2'd1;
  localparam logic [1:0] MSIX_ST_TIMEOUT = 2'd2;

endpackage

// File: rtl/pcie_msix_rr_arb.sv
// pcie_msix_rr_arb
//   Combinational round-robin priority select. The search starts at ptr and
//   walks upward with wrap; the first set request wins.
//   req       in  CHANNELS : request vector
//   ptr       in  CL_CH    : highest-priority channel this cycle
//   grant_oh  out CHANNELS : one-hot winner (zero if no request)
//   grant_idx out CL_CH    : encoded winner
//   any_vld   out 1        : at least one request set
module pcie_msix_rr_arb #(
  parameter int CHANNELS = 4,
  parameter int CL_CH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [CL_CH-1:0]    ptr,
  output logic [CHANNELS-1:0] grant_oh,
  output logic [CL_CH-1:0]    grant_idx,
  output logic                any_vld
);

  always_comb begin
    int  j;
    logic found;
    grant_oh  = '0;
    grant_idx = '0;
    any_vld   = |req;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      // ptr is always < CHANNELS, so one subtraction is enough to wrap
      j = int'(ptr) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!found && req[j]) begin
        found       = 1'b1;
        grant_oh[j] = 1'b1;
        grant_idx   = CL_CH'(j);
      end
    end
  end

endmodule

// File: rtl/pcie_us_msix_arb.sv
// pcie_us_msix_arb
//   Multi-channel MSI-X request engine for the UltraScale PCIe
//   cfg_interrupt_msix_* interface. Round-robin arbitration across CHANNELS
//   request streams, one outstanding write at a time, retry on fail up to
//   RETRY_LIMIT, one status pulse per completed request.
//   Optional: define PCIE_MSIX_TIMEOUT_EN to bound WAIT by TIMEOUT_CYCLES.
// Ports
//   clk, rst                   : clock, async active-high reset
//   s_req_valid/ready/addr/data: per-channel request streams (packed)
//   cfg_interrupt_msix_*       : PCIe IP interrupt interface
//   m_status_valid/channel/code: completion report
//   busy                       : FSM not in IDLE
module pcie_us_msix_arb
  import pcie_msix_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int RETRY_LIMIT    = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CL_CH          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [CHANNELS-1:0]    s_req_valid,
  output logic [CHANNELS-1:0]    s_req_ready,
  input  logic [CHANNELS*64-1:0] s_req_addr,
  input  logic [CHANNELS*32-1:0] s_req_data,
  input  logic [3:0]             cfg_interrupt_msix_enable,
  input  logic [3:0]             cfg_interrupt_msix_mask,
  output logic [63:0]            cfg_interrupt_msix_address,
  output logic [31:0]            cfg_interrupt_msix_data,
  output logic                   cfg_interrupt_msix_int,
  input  logic                   cfg_interrupt_msix_sent,
  input  logic                   cfg_interrupt_msix_fail,
  output logic                   m_status_valid,
  output logic [CL_CH-1:0]       m_status_channel,
  output logic [1:0]             m_status_code,
  output logic                   busy
);

  localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

  logic [1:0]       state_q, state_d;
  logic [CL_CH-1:0] rr_ptr_q, rr_ptr_d;
  logic [CL_CH-1:0] ch_q, ch_d;
  logic [63:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             st_vld_q, st_vld_d;
  logic [1:0]       st_code_q, st_code_d;

  logic [CHANNELS-1:0] grant_oh;
  logic [CL_CH-1:0]    grant_idx;
  logic                any_vld;
  logic                en_ok;
  logic                do_grant;

  // Only function 0 is served; upper enable/mask bits are intentionally ignored
  logic unused_cfg;
  assign unused_cfg = ^{cfg_interrupt_msix_enable[3:1], cfg_interrupt_msix_mask[3:1]};

  pcie_msix_rr_arb #(
    .CHANNELS (CHANNELS),
    .CL_CH    (CL_CH)
  ) u_rr_arb (
    .req       (s_req_valid),
    .ptr       (rr_ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any_vld   (any_vld)
  );

  assign en_ok    = cfg_interrupt_msix_enable[0] & ~cfg_interrupt_msix_mask[0];
  assign do_grant = (state_q == ST_IDLE) & en_ok & any_vld;

`ifdef PCIE_MSIX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_q, to_d;
  logic          to_hit;

  // Held at zero outside WAIT so it is clear on every entry to WAIT
  assign to_d   = (state_q == ST_WAIT) ? to_q + 1'b1 : '0;
  assign to_hit = (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) to_q <= '0;
    else     to_q <= to_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    ch_d      = ch_q;
    addr_d    = addr_q;
    data_d    = data_q;
    retry_d   = retry_q;
    st_vld_d  = 1'b0;
    st_code_d = st_code_q;
    case (state_q)
      ST_IDLE: begin
        if (do_grant) begin
          ch_d     = grant_idx;
          addr_d   = s_req_addr[int'(grant_idx)*64 +: 64];
          data_d   = s_req_data[int'(grant_idx)*32 +: 32];
          retry_d  = '0;
          rr_ptr_d = (grant_idx == CL_CH'(CHANNELS - 1)) ? '0 : grant_idx + 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // sent wins over a simultaneous fail
        if (cfg_interrupt_msix_sent) begin
          st_vld_d  = 1'b1;
          st_code_d = MSIX_ST_OK;
          state_d   = ST_IDLE;
        end else if (cfg_interrupt_msix_fail) begin
          if (int'(retry_q) < RETRY_LIMIT) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_HOLDOFF;
          end else begin
            st_vld_d  = 1'b1;
            st_code_d = MSIX_ST_FAIL;
            state_d   = ST_IDLE;
          end
        end
`ifdef PCIE_MSIX_TIMEOUT_EN
        else if (to_hit) begin
          st_vld_d  = 1'b1;
          st_code_d = MSIX_ST_TIMEOUT;
          state_d   = ST_IDLE;
        end
`endif
      end
      ST_HOLDOFF: state_d = ST_ISSUE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      ch_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      retry_q   <= '0;
      st_vld_q  <= 1'b0;
      st_code_q <= MSIX_ST_OK;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      ch_q      <= ch_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      retry_q   <= retry_d;
      st_vld_q  <= st_vld_d;
      st_code_q <= st_code_d;
    end
  end

  assign s_req_ready                = do_grant ? grant_oh : '0;
  assign cfg_interrupt_msix_int     = (state_q == ST_ISSUE);
  assign cfg_interrupt_msix_address = addr_q;
  assign cfg_interrupt_msix_data    = data_q;
  // ch_q cannot change before the status cycle ends: a new grant made in
  // that cycle only lands at the following edge
  assign m_status_valid             = st_vld_q;
  assign m_status_channel           = ch_q;
  assign m_status_code              = st_code_q;
  assign busy                       = (state_q != ST_IDLE);

endmodule
